// File: rtl/picomips_seq.sv
// picoMIPS multi-cycle control sequencer: fetch/decode/execute FSM with
// Mealy control outputs, multiplier and switch-port handshakes, retired counter.
module picomips_seq #(
  parameter int OPW = 3,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mul_done,
  input  logic           sw_valid,
  output logic           ir_load,
  output logic           pc_incr,
  output logic           pc_rel,
  output logic           pc_abs,
  output logic           reg_we,
  output logic [1:0]     wb_sel,
  output logic           alu_sub,
  output logic           alu_imm,
  output logic           mul_start,
  output logic           sw_ack,
  output logic           busy,
  output logic [CW-1:0]  retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT_MUL,
    S_WAIT_SW
  } state_t;

  localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(3);
  localparam logic [OPW-1:0] OP_MULI = OPW'(4);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(5);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(6);
  localparam logic [OPW-1:0] OP_WSW  = OPW'(7);

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MUL = 2'b01;
  localparam logic [1:0] WB_SW  = 2'b10;

  state_t          state_q, state_d;
  logic [CW-1:0]   retired_q, retired_d;

  logic            ir_load_c, pc_incr_c, pc_rel_c, pc_abs_c, reg_we_c;
  logic [1:0]      wb_sel_c;
  logic            alu_sub_c, alu_imm_c, mul_start_c, sw_ack_c, busy_c;
  logic            pc_strobe;

  always_comb begin
    state_d     = state_q;
    ir_load_c   = 1'b0;
    pc_incr_c   = 1'b0;
    pc_rel_c    = 1'b0;
    pc_abs_c    = 1'b0;
    reg_we_c    = 1'b0;
    wb_sel_c    = WB_ALU;
    alu_sub_c   = 1'b0;
    alu_imm_c   = 1'b0;
    mul_start_c = 1'b0;
    sw_ack_c    = 1'b0;
    busy_c      = 1'b1;

    unique case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_load_c = 1'b1;
          state_d   = S_DECODE;
        end else begin
          busy_c = 1'b0;
        end
      end

      S_DECODE: state_d = S_EXEC;

      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_NOP: pc_incr_c = 1'b1;
          OP_ADD: begin
            reg_we_c  = 1'b1;
            pc_incr_c = 1'b1;
          end
          OP_ADDI: begin
            reg_we_c  = 1'b1;
            alu_imm_c = 1'b1;
            pc_incr_c = 1'b1;
          end
          OP_SUB: begin
            reg_we_c  = 1'b1;
            alu_sub_c = 1'b1;
            pc_incr_c = 1'b1;
          end
          OP_MULI: begin
            alu_imm_c   = 1'b1;
            mul_start_c = 1'b1;
            state_d     = S_WAIT_MUL;
          end
          OP_BEQ: begin
            alu_sub_c = 1'b1;
            if (zero) pc_rel_c  = 1'b1;
            else      pc_incr_c = 1'b1;
          end
          OP_JMP: pc_abs_c = 1'b1;
          OP_WSW: state_d = S_WAIT_SW;
          default: pc_incr_c = 1'b1;
        endcase
      end

      // Immediate operand stays selected so the multiplier sees a stable B input.
      S_WAIT_MUL: begin
        alu_imm_c = 1'b1;
        if (mul_done) begin
          reg_we_c  = 1'b1;
          wb_sel_c  = WB_MUL;
          pc_incr_c = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_WAIT_SW: begin
        if (sw_valid) begin
          reg_we_c  = 1'b1;
          wb_sel_c  = WB_SW;
          sw_ack_c  = 1'b1;
          pc_incr_c = 1'b1;
          state_d   = S_FETCH;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every control output low regardless of the state decode.
  assign ir_load   = ir_load_c   & ~reset;
  assign pc_incr   = pc_incr_c   & ~reset;
  assign pc_rel    = pc_rel_c    & ~reset;
  assign pc_abs    = pc_abs_c    & ~reset;
  assign reg_we    = reg_we_c    & ~reset;
  assign wb_sel    = reset ? 2'b00 : wb_sel_c;
  assign alu_sub   = alu_sub_c   & ~reset;
  assign alu_imm   = alu_imm_c   & ~reset;
  assign mul_start = mul_start_c & ~reset;
  assign sw_ack    = sw_ack_c    & ~reset;
  assign busy      = busy_c      & ~reset;
  assign retired   = retired_q;

  assign pc_strobe = pc_incr | pc_rel | pc_abs;

  always_comb begin
    retired_d = retired_q;
    if (pc_strobe && (retired_q != {CW{1'b1}})) retired_d = retired_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  a_pc_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0({pc_incr, pc_rel, pc_abs}));
  a_we_strobe: assert property (@(posedge clk) disable iff (reset)
    reg_we |-> pc_strobe);
  a_wb_legal: assert property (@(posedge clk) disable iff (reset)
    wb_sel != 2'b11);

endmodule

// File: doc/picomips_seq.md
Name: picomips_seq

Overview:
Multi-cycle control sequencer for the picoMIPS core. It fetches each instruction, decodes its opcode, and drives the program-counter update strobes (pc_incr / pc_rel / pc_abs). It also drives register-file write, ALU and writeback controls, and handshakes with the multi-cycle multiplier and the switch-input port. It sits between the instruction register/decoder and the PC, register file, ALU and multiplier.

Parameters:
OPW, 3, opcode field width (opcode map below is fixed for OPW=3)
CW, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  1 = allow new instruction fetch
opcode  input  OPW  opcode of the instruction held in IR, valid from DECODE onward
zero  input  1  ALU zero flag (Rs==Rt compare), sampled in EXEC
mul_done  input  1  multiplier result valid pulse/level
sw_valid  input  1  switch port holds new data
ir_load  output  1  load instruction register
pc_incr  output  1  PC += 1
pc_rel  output  1  PC += branch offset
pc_abs  output  1  PC = branch address
reg_we  output  1  register-file write enable
wb_sel  output  2  00 ALU, 01 MUL, 10 SW, 11 unused
alu_sub  output  1  ALU subtract
alu_imm  output  1  ALU B operand = immediate
mul_start  output  1  one-cycle multiplier start
sw_ack  output  1  one-cycle switch-data consume
busy  output  1  1 in any state except FETCH-with-run=0
retired  output  CW  count of completed instructions

Behaviour:
- Reset (async, reset=1): state=FETCH, retired=0. All outputs are 0 while reset is high, independent of state.
- State register and counter use flops. Outputs are combinational (Mealy) decode of state, opcode, and handshake inputs.
- Opcodes: 000 NOP, 001 ADD, 010 ADDI, 011 SUB, 100 MULI, 101 BEQ, 110 JMP, 111 WSW (wait for switch).
- FETCH: if run=1 -> ir_load=1, next DECODE. Else stay, all outputs 0, busy=0.
- DECODE: no strobes, next EXEC. This is one pipeline bubble for register read.
- EXEC, per opcode:
  - NOP: pc_incr=1 -> FETCH.
  - ADD: reg_we=1, wb_sel=00, pc_incr=1 -> FETCH.
  - ADDI: as ADD plus alu_imm=1.
  - SUB: as ADD plus alu_sub=1.
  - MULI: alu_imm=1, mul_start=1 -> WAIT_MUL. No PC strobe.
  - BEQ: alu_sub=1. zero=1 -> pc_rel=1, else pc_incr=1. Then -> FETCH.
  - JMP: pc_abs=1 -> FETCH.
  - WSW: -> WAIT_SW, no strobes.
- WAIT_MUL: alu_imm held 1. mul_done=0 -> stay, no strobes. mul_done=1 -> reg_we=1, wb_sel=01, pc_incr=1 in that same cycle -> FETCH. mul_done already high on the first WAIT_MUL cycle completes immediately.
- WAIT_SW: sw_valid=0 -> stay. sw_valid=1 -> reg_we=1, wb_sel=10, sw_ack=1, pc_incr=1 -> FETCH.
- Invariants:
  - At most one of pc_incr/pc_rel/pc_abs per cycle.
  - Exactly one PC strobe per instruction, always in its final cycle.
  - reg_we is never high without a PC strobe.
  - mul_start and sw_ack are single-cycle pulses.
- Latency: ALU, NOP, branch and jump take 3 cycles (FETCH, DECODE, EXEC). MULI and WSW take 3+N cycles, N = wait cycles including the completing one (N≥1).
- run is sampled only in FETCH. Deasserting run mid-instruction does not stall completion.
- retired increments by 1 on every cycle with a PC strobe. It saturates at 2^CW-1 and does not wrap.
- Reset mid-instruction (e.g. in WAIT_MUL) aborts it: no strobe, next state FETCH, retired=0.
- Encoding 11 on wb_sel is never driven.

Test Plan:
- Reset high 3 cycles, then low with run=1, opcode=001 -> cycle 1 ir_load=1; cycle 3 reg_we=1, wb_sel=00, pc_incr=1; retired=1 after that edge.
- BEQ with zero=1 -> pc_rel=1, pc_incr=0 in EXEC. Repeat with zero=0 -> pc_incr=1, pc_rel=0. JMP -> pc_abs=1 only.
- MULI with mul_done raised 4 cycles after EXEC -> mul_start=1 exactly in EXEC. 3 idle WAIT_MUL cycles with no strobes, then reg_we=1, wb_sel=01, pc_incr=1 together. Instruction total 7 cycles.
- WSW with sw_valid=1 already high -> WAIT_SW completes on its first cycle: sw_ack=1, wb_sel=10, reg_we=1, pc_incr=1. Instruction total 4 cycles.
- run=0 at FETCH for 5 cycles -> ir_load=0, busy=0, retired unchanged. run drops during DECODE -> instruction still completes.
- Assert reset during WAIT_MUL -> all outputs 0 immediately (async). After release, state is FETCH and retired=0. Preload retired near max via 2^CW-1 strobes (CW=4 build) -> counter holds at 15.
